// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, segment table and slot-length helper for the seven-segment scanner.
package seg7_pkg;

   typedef enum logic {BLANK, DRIVE} state_t;

   typedef struct packed {
      logic [15:0] val;
      logic [3:0]  dp;
   } disp_t;

   // Active-low g..a patterns, index = hex value.
   localparam logic [15:0][6:0] SEG_TBL = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic int calc_div(input int clk_hz, input int refresh_hz);
      return clk_hz / (refresh_hz * 4);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to active-low segments, with forced blank and decimal point.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   input  logic       dp_i,
   output logic [6:0] seg_n_o,
   output logic       dp_n_o
);

   assign seg_n_o = blank_i ? 7'h7F : SEG_TBL[nib_i];
   assign dp_n_o  = ~dp_i;

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed display driver with frame-aligned loads,
// per-slot anode blanking and optional leading-zero suppression.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 500,
   parameter int LZ_SUPPRESS  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digit_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic        frame_tick
);

   localparam int DIV = calc_div(CLK_HZ, REFRESH_HZ);
   localparam int PW  = $clog2(DIV);

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      idx_q, idx_d;
   disp_t           din, shadow_q, shadow_d, act_q, act_d;
   logic            pend_q, pend_d;
   logic [6:0]      seg_q, seg_d, dec_seg;
   logic            dp_q, dp_d, dec_dp;
   logic [3:0]      an_q, an_d, nz;
   logic            tick_q, slot_end, wrap, lz_blank;

   assign din = '{val: digit_in, dp: dp_in};
   assign nz  = {act_q.val[15:12] == 4'd0, act_q.val[11:8] == 4'd0,
                 act_q.val[7:4] == 4'd0, act_q.val[3:0] == 4'd0};
   // Digit idx is a leading zero when every nibble from idx upward is zero.
   assign lz_blank = LZ_SUPPRESS != 0 && idx_q != 2'd0 && &(nz | ~(4'hF << idx_q));

   seg7_decode u_dec (
      .nib_i   (act_q.val[{idx_q, 2'b00} +: 4]),
      .blank_i (lz_blank),
      .dp_i    (act_q.dp[idx_q]),
      .seg_n_o (dec_seg),
      .dp_n_o  (dec_dp)
   );

   always_comb begin
      slot_end = state_q == DRIVE && presc_q == PW'(DIV - 1);
      wrap     = slot_end && idx_q == 2'd3;
      presc_d  = slot_end ? '0 : presc_q + 1'b1;
      state_d  = state_q == BLANK ? (presc_q == PW'(BLANK_CYCLES - 1) ? DRIVE : BLANK)
                                  : (slot_end ? BLANK : DRIVE);
      idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
      shadow_d = load ? din : shadow_q;
      // A load on the wrap cycle bypasses the shadow so the newest data wins.
      act_d    = wrap ? (load ? din : pend_q ? shadow_q : act_q) : act_q;
      pend_d   = !wrap && (load || pend_q);
      an_d     = state_q == DRIVE ? ~(4'b0001 << idx_q) : 4'hF;
      seg_d    = state_q == BLANK ? dec_seg : seg_q;
      dp_d     = state_q == BLANK ? dec_dp : dp_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= BLANK;
         presc_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         act_q    <= '0;
         pend_q   <= 1'b0;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
         an_q     <= 4'hF;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         act_q    <= act_d;
         pend_q   <= pend_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
         tick_q   <= wrap;
      end
   end

   assign seg_n      = seg_q;
   assign dp_n       = dp_q;
   assign an_n       = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed frame-by-frame checks of two scanner instances (plain and leading-zero suppressed).
module tb_seg7_scan;

   logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
   logic [15:0] digit_in = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg0, seg1;
   logic        dpn0, dpn1, tick0, tick1;
   logic [3:0]  an0, an1;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   seg7_scan #(.CLK_HZ(1000), .REFRESH_HZ(50), .BLANK_CYCLES(1), .LZ_SUPPRESS(0)) u_dut (
      .clk(clk), .rst(rst), .digit_in(digit_in), .dp_in(dp_in), .load(load),
      .seg_n(seg0), .dp_n(dpn0), .an_n(an0), .frame_tick(tick0));

   seg7_scan #(.CLK_HZ(1000), .REFRESH_HZ(50), .BLANK_CYCLES(1), .LZ_SUPPRESS(1)) u_lz (
      .clk(clk), .rst(rst), .digit_in(digit_in), .dp_in(dp_in), .load(load),
      .seg_n(seg1), .dp_n(dpn1), .an_n(an1), .frame_tick(tick1));

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Expected {an_n, seg_n, dp_n, frame_tick} after cycle c (1..20) of a frame showing v/dp.
   function automatic logic [12:0] model(input logic [15:0] v, input logic [3:0] dp, input bit lz, input int c);
      logic [1:0] s;
      logic [3:0] an;
      logic       blank;
      s     = 2'((c - 1) / 5);
      an    = ((c - 1) % 5 == 0) ? 4'hF : ~(4'b0001 << s);
      blank = lz && s != 2'd0 && (v >> {s, 2'b00}) == 16'h0;
      return {an, blank ? 7'h7F : hex_seg(v[{s, 2'b00} +: 4]), ~dp[s], c == 20};
   endfunction

   task automatic scan_frame(input string nm, input logic [15:0] v, input logic [3:0] dp,
                             input int ld_at, input logic [15:0] lv, input logic [3:0] ldp,
                             input int ld2_at, input logic [15:0] lv2, input int rst_at);
      logic [12:0] e0, e1, a0, a1;
      for (int i = 1; i <= 20; i++) begin
         load     = (i == ld_at) || (i == ld2_at);
         digit_in = (i == ld2_at) ? lv2 : lv;
         dp_in    = (i == ld2_at) ? 4'h0 : ldp;
         rst      = (i == rst_at);
         @(negedge clk);
         e0 = rst ? {4'hF, 7'h7F, 1'b1, 1'b0} : model(v, dp, 1'b0, i);
         e1 = rst ? {4'hF, 7'h7F, 1'b1, 1'b0} : model(v, dp, 1'b1, i);
         a0 = {an0, seg0, dpn0, tick0};
         a1 = {an1, seg1, dpn1, tick1};
         total += 2;
         if (a0 !== e0) begin
            bad++;
            $display("FAIL %s plain cyc=%0d got an/seg/dp/tick=%b want %b", nm, i, a0, e0);
         end
         if (a1 !== e1) begin
            bad++;
            $display("FAIL %s lz cyc=%0d got an/seg/dp/tick=%b want %b", nm, i, a1, e1);
         end
         if (rst) break;
      end
      load = 1'b0;
      rst  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total += 2;
      if ({an0, seg0, dpn0, tick0} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset plain got %b want %b", {an0, seg0, dpn0, tick0}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      if ({an1, seg1, dpn1, tick1} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset lz got %b want %b", {an1, seg1, dpn1, tick1}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      rst = 1'b0;
   endtask

   task automatic test_idle;
      scan_frame("idle0", 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
      scan_frame("idle1", 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
   endtask

   task automatic test_midframe_load;
      scan_frame("mid_cur", 16'h0, 4'h0, 7, 16'h8F71, 4'b0100, 0, 16'h0, 0);
      scan_frame("mid_next", 16'h8F71, 4'b0100, 0, 16'h0, 4'h0, 0, 16'h0, 0);
   endtask

   task automatic test_boundary_load;
      scan_frame("bnd_cur", 16'h8F71, 4'b0100, 6, 16'hAAAA, 4'hF, 20, 16'h1234, 0);
      scan_frame("bnd_next", 16'h1234, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
   endtask

   task automatic test_lz;
      scan_frame("lz_cur", 16'h1234, 4'h0, 4, 16'h0070, 4'h0, 0, 16'h0, 0);
      scan_frame("lz_0070", 16'h0070, 4'h0, 10, 16'h0000, 4'h0, 0, 16'h0, 0);
      scan_frame("lz_0000", 16'h0000, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
   endtask

   task automatic test_rst_pending;
      scan_frame("rst_cur", 16'h0, 4'h0, 3, 16'h5678, 4'hF, 0, 16'h0, 13);
      scan_frame("rst_f0", 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
      scan_frame("rst_f1", 16'h0, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 0);
   endtask

   initial begin
      test_reset;
      test_idle;
      test_midframe_load;
      test_boundary_load;
      test_lz;
      test_rst_pending;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
